// File: rtl/sw_input_scanner.sv
// sw_input_scanner: samples WIDTH raw board switches, synchronises and debounces
// them, and reports each debounced transition as one event over valid/ready.
//
// Ports:
//   clk          system clock, all logic on posedge
//   rst          synchronous reset, active-low
//   sw_raw       asynchronous raw switch levels
//   sw_stable    debounced switch levels
//   evt_valid    change event presented
//   evt_ready    consumer accepts event when evt_valid && evt_ready
//   evt_idx      index of the switch that changed
//   evt_rise     1 = new level high, 0 = new level low
//   evt_overflow sticky: a pending event was overwritten before being sent
//
// Build option: define SW_DEBOUNCE_BYPASS_EN to drop the tick counter and
// sample history; sw_stable then follows the synchroniser every cycle.
module sw_input_scanner #(
  parameter int unsigned WIDTH           = 16,
  parameter int unsigned DEBOUNCE_CYCLES = 500000,
  parameter int unsigned IDX_W           = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] sw_raw,
  output logic [WIDTH-1:0] sw_stable,
  output logic             evt_valid,
  input  logic             evt_ready,
  output logic [IDX_W-1:0] evt_idx,
  output logic             evt_rise,
  output logic             evt_overflow
);

  logic [WIDTH-1:0] sync_q1, sync_q2;
  logic [WIDTH-1:0] stable_d;

  // Two-flop synchroniser per switch
  always_ff @(posedge clk) begin
    if (!rst) begin
      sync_q1 <= '0;
      sync_q2 <= '0;
    end else begin
      sync_q1 <= sw_raw;
      sync_q2 <= sync_q1;
    end
  end

`ifdef SW_DEBOUNCE_BYPASS_EN
  assign stable_d = sync_q2;
`else
  localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES) + 1;

  logic [CNT_W-1:0] tick_cnt;
  logic             tick;
  logic [WIDTH-1:0] hist_old, hist_new;
  logic [WIDTH-1:0] agree;

  assign tick = (tick_cnt == CNT_W'(DEBOUNCE_CYCLES - 1));

  // Debounce sample strobe
  always_ff @(posedge clk) begin
    if (!rst)      tick_cnt <= '0;
    else if (tick) tick_cnt <= '0;
    else           tick_cnt <= tick_cnt + CNT_W'(1);
  end

  // Two previous tick samples per switch
  always_ff @(posedge clk) begin
    if (!rst) begin
      hist_old <= '0;
      hist_new <= '0;
    end else if (tick) begin
      hist_old <= hist_new;
      hist_new <= sync_q2;
    end
  end

  // A bit is accepted only when the current sample matches the two before it
  assign agree    = ~(hist_old ^ hist_new) & ~(hist_new ^ sync_q2);
  assign stable_d = tick ? ((sw_stable & ~agree) | (sync_q2 & agree)) : sw_stable;
`endif

  logic [WIDTH-1:0] pend, pend_d;
  logic [WIDTH-1:0] dir, dir_d;
  logic [WIDTH-1:0] chg, clr;
  logic             empty, have_pend, load, ovf_d, valid_d, rise_d;
  logic [IDX_W-1:0] sel_idx, idx_d;

  // Next-state for pending set and event output register
  always_comb begin
    have_pend = 1'b0;
    sel_idx   = '0;
    valid_d   = evt_valid;
    idx_d     = evt_idx;
    rise_d    = evt_rise;

    chg   = stable_d ^ sw_stable;
    empty = !evt_valid || evt_ready;

    // Lowest pending index wins
    for (int unsigned i = 0; i < WIDTH; i++) begin
      if (pend[i] && !have_pend) begin
        have_pend = 1'b1;
        sel_idx   = IDX_W'(i);
      end
    end

    load = empty && have_pend;
    clr  = load ? (WIDTH'(1) << sel_idx) : '0;

    // A new change on a bit being loaded re-arms it without counting as overflow
    pend_d = (pend & ~clr) | chg;
    dir_d  = (dir & ~chg) | (stable_d & chg);
    ovf_d  = evt_overflow | (|(chg & pend & ~clr));

    if (empty) begin
      valid_d = have_pend;
      if (have_pend) begin
        idx_d  = sel_idx;
        rise_d = dir[sel_idx];
      end
    end
  end

  // State and output registers
  always_ff @(posedge clk) begin
    if (!rst) begin
      sw_stable    <= '0;
      pend         <= '0;
      dir          <= '0;
      evt_valid    <= 1'b0;
      evt_idx      <= '0;
      evt_rise     <= 1'b0;
      evt_overflow <= 1'b0;
    end else begin
      sw_stable    <= stable_d;
      pend         <= pend_d;
      dir          <= dir_d;
      evt_valid    <= valid_d;
      evt_idx      <= idx_d;
      evt_rise     <= rise_d;
      evt_overflow <= ovf_d;
    end
  end

endmodule

// File: tb/tb_sw_input_scanner.sv
// Directed bench for sw_input_scanner (WIDTH=4, DEBOUNCE_CYCLES=4).
module tb_sw_input_scanner;
  localparam int unsigned WIDTH = 4;
  localparam int unsigned DEB   = 4;
  localparam int unsigned IDX_W = 2;

  logic             clk = 1'b0;
  logic             rst;
  logic [WIDTH-1:0] sw_raw;
  logic [WIDTH-1:0] sw_stable;
  logic             evt_valid;
  logic             evt_ready;
  logic [IDX_W-1:0] evt_idx;
  logic             evt_rise;
  logic             evt_overflow;

  int checks = 0;
  int errors = 0;

  logic [2:0] evq[$];   // accepted events as {rise, idx}
  bit         seen_valid;

  always #5 clk = ~clk;

  sw_input_scanner #(.WIDTH(WIDTH), .DEBOUNCE_CYCLES(DEB)) dut (
    .clk(clk), .rst(rst), .sw_raw(sw_raw), .sw_stable(sw_stable),
    .evt_valid(evt_valid), .evt_ready(evt_ready), .evt_idx(evt_idx),
    .evt_rise(evt_rise), .evt_overflow(evt_overflow)
  );

  // Inputs only change just after posedge, so a negedge sample predicts the handshake
  always @(negedge clk) begin
    if (rst && evt_valid) begin
      seen_valid = 1'b1;
      if (evt_ready) evq.push_back({evt_rise, evt_idx});
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_stable(input int exp, input int bound, input string tag);
    int i = 0;
    while (32'(sw_stable) !== exp && i < bound) begin
      step(1);
      i++;
    end
    chk(tag, 32'(sw_stable), exp);
  endtask

  initial begin
    rst       = 1'b0;
    sw_raw    = '0;
    evt_ready = 1'b1;
    seen_valid = 1'b0;

    // 1: reset values and quiet run
    step(3);
    chk("rst_stable",   32'(sw_stable), 0);
    chk("rst_valid",    32'(evt_valid), 0);
    chk("rst_idx",      32'(evt_idx), 0);
    chk("rst_rise",     32'(evt_rise), 0);
    chk("rst_overflow", 32'(evt_overflow), 0);
    rst = 1'b1;
    step(40);
    chk("idle_events", 32'(evq.size()), 0);
    chk("idle_valid_seen", 32'(seen_valid), 0);

`ifdef SW_DEBOUNCE_BYPASS_EN
    // 7: bypass path, raw edge reaches sw_stable in 3 cycles
    sw_raw = 4'b0010;
    step(2);
    chk("byp_stable_early", 32'(sw_stable), 0);
    step(1);
    chk("byp_stable", 32'(sw_stable), 2);
    chk("byp_valid_early", 32'(evt_valid), 0);
    step(1);
    chk("byp_valid", 32'(evt_valid), 1);
    chk("byp_idx",   32'(evt_idx), 1);
    chk("byp_rise",  32'(evt_rise), 1);
`else
    // 2: single rise
    sw_raw = 4'b0100;
    wait_stable(4, 16, "t2_stable");
    step(10);
    chk("t2_evt_count", 32'(evq.size()), 1);
    if (evq.size() == 1) chk("t2_evt", 32'(evq[0]), 32'h6);

    // 3: short pulse filtered
    seen_valid = 1'b0;
    sw_raw = 4'b0110;
    step(5);
    sw_raw = 4'b0100;
    step(30);
    chk("t3_stable", 32'(sw_stable), 4);
    chk("t3_no_valid", 32'(seen_valid), 0);

    // 4: simultaneous rises served in index order with backpressure
    evq.delete();
    evt_ready = 1'b0;
    sw_raw = 4'b1101;
    wait_stable(13, 16, "t4_stable");
    step(10);
    chk("t4_hold_valid", 32'(evt_valid), 1);
    chk("t4_hold_idx",   32'(evt_idx), 0);
    chk("t4_hold_rise",  32'(evt_rise), 1);
    evt_ready = 1'b1;
    step(1);
    evt_ready = 1'b0;
    chk("t4_next_valid", 32'(evt_valid), 1);
    chk("t4_next_idx",   32'(evt_idx), 3);
    chk("t4_next_rise",  32'(evt_rise), 1);
    evt_ready = 1'b1;
    step(1);
    evt_ready = 1'b0;
    chk("t4_drained", 32'(evt_valid), 0);
    chk("t4_evt_count", 32'(evq.size()), 2);
    chk("t4_overflow", 32'(evt_overflow), 0);

    // drain back to all-low
    evt_ready = 1'b1;
    sw_raw = 4'b0000;
    wait_stable(0, 16, "drain_stable");
    step(6);
    chk("drain_valid", 32'(evt_valid), 0);

    // 5: overwrite of a pending event sets the sticky overflow
    evq.delete();
    evt_ready = 1'b0;
    sw_raw = 4'b1000;
    wait_stable(8, 16, "t5_stable_b3");
    step(2);
    chk("t5_held_idx", 32'(evt_idx), 3);
    sw_raw = 4'b1001;
    wait_stable(9, 16, "t5_stable_b0_hi");
    chk("t5_no_overflow_yet", 32'(evt_overflow), 0);
    sw_raw = 4'b1000;
    wait_stable(8, 16, "t5_stable_b0_lo");
    chk("t5_overflow", 32'(evt_overflow), 1);
    step(5);
    chk("t5_overflow_sticky", 32'(evt_overflow), 1);
    evt_ready = 1'b1;
    step(5);
    chk("t5_evt_count", 32'(evq.size()), 2);
    if (evq.size() == 2) begin
      chk("t5_evt0", 32'(evq[0]), 32'h7);
      chk("t5_evt1", 32'(evq[1]), 32'h0);
    end
    chk("t5_overflow_after", 32'(evt_overflow), 1);

    // 6: reset with an event presented and more pending
    evt_ready = 1'b0;
    sw_raw = 4'b0111;
    wait_stable(7, 16, "t6_stable");
    step(2);
    chk("t6_valid_before", 32'(evt_valid), 1);
    rst = 1'b0;
    sw_raw = 4'b0000;
    step(1);
    chk("t6_stable",   32'(sw_stable), 0);
    chk("t6_valid",    32'(evt_valid), 0);
    chk("t6_idx",      32'(evt_idx), 0);
    chk("t6_rise",     32'(evt_rise), 0);
    chk("t6_overflow", 32'(evt_overflow), 0);
    step(1);
    rst = 1'b1;
    evq.delete();
    seen_valid = 1'b0;
    evt_ready = 1'b1;
    step(40);
    chk("t6_no_stale", 32'(seen_valid), 0);
    chk("t6_stable_after", 32'(sw_stable), 0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
